// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two writeback sources, the arbiter and the register-file write port.
// Master is the source/register-file side, slave is the arbiter.
interface regfile_wb_arbiter_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 16
);
  logic                  valA;
  logic [ADDR_WIDTH-1:0] regA;
  logic [DATA_WIDTH-1:0] dataA;
  logic                  rdyA;
  logic                  valB;
  logic [ADDR_WIDTH-1:0] regB;
  logic [DATA_WIDTH-1:0] dataB;
  logic                  rdyB;
  logic                  hold;
  logic                  write;
  logic [ADDR_WIDTH-1:0] writeReg;
  logic [DATA_WIDTH-1:0] writeData;
  logic                  pendValid;
  logic [ADDR_WIDTH-1:0] pendReg;
  logic [DATA_WIDTH-1:0] pendData;
  logic [CNT_WIDTH-1:0]  cntA;
  logic [CNT_WIDTH-1:0]  cntB;
  logic [CNT_WIDTH-1:0]  cntZero;

  modport master (
    output valA, regA, dataA, valB, regB, dataB, hold,
    input  rdyA, rdyB, write, writeReg, writeData,
    input  pendValid, pendReg, pendData, cntA, cntB, cntZero
  );

  modport slave (
    input  valA, regA, dataA, valB, regB, dataB, hold,
    output rdyA, rdyB, write, writeReg, writeData,
    output pendValid, pendReg, pendData, cntA, cntB, cntZero
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU (A) and load (B) writebacks,
// with a one-entry output stage exposed for bypass and per-source transfer statistics.
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 16
) (
  input logic clk,
  input logic rst,
  regfile_wb_arbiter_if.slave bus
);

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_t;

  localparam logic [ADDR_WIDTH-1:0] ZERO_REG = '1;
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                  stageValid;
  logic [ADDR_WIDTH-1:0] stageReg;
  logic [DATA_WIDTH-1:0] stageData;
  prio_t                 prio;
  logic [CNT_WIDTH-1:0]  cntA;
  logic [CNT_WIDTH-1:0]  cntB;
  logic [CNT_WIDTH-1:0]  cntZero;

  logic                  canAccept;
  logic                  grantA;
  logic                  grantB;
  logic                  rdyA;
  logic                  rdyB;
  logic                  xferA;
  logic                  xferB;
  logic [ADDR_WIDTH-1:0] selReg;
  logic [DATA_WIDTH-1:0] selData;

  // A contested cycle goes to the source prio favours; a lone requester always wins.
  always_comb begin
    canAccept = !stageValid || !bus.hold;
    grantA    = bus.valA && (!bus.valB || (prio == PRIO_A));
    grantB    = bus.valB && (!bus.valA || (prio == PRIO_B));
    rdyA      = grantA && canAccept;
    rdyB      = grantB && canAccept;
    xferA     = bus.valA && rdyA;
    xferB     = bus.valB && rdyB;
    selReg    = xferB ? bus.regB  : bus.regA;
    selData   = xferB ? bus.dataB : bus.dataA;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stageValid <= 1'b0;
      stageReg   <= '0;
      stageData  <= '0;
      prio       <= PRIO_A;
      cntA       <= '0;
      cntB       <= '0;
      cntZero    <= '0;
    end else begin
      if (xferA || xferB) begin
        stageValid <= 1'b1;
        stageReg   <= selReg;
        stageData  <= selData;
        prio       <= xferA ? PRIO_B : PRIO_A;
        if (selReg == ZERO_REG) begin
          cntZero <= cntZero + CNT_ONE;
        end
      end else if (stageValid && !bus.hold) begin
        stageValid <= 1'b0;
      end
      if (xferA) begin
        cntA <= cntA + CNT_ONE;
      end
      if (xferB) begin
        cntB <= cntB + CNT_ONE;
      end
    end
  end

  // Reset discards the staged entry, so the write enable is masked while rst is high.
  assign bus.write     = stageValid && !bus.hold && !rst && (stageReg != ZERO_REG);
  assign bus.writeReg  = stageReg;
  assign bus.writeData = stageData;
  assign bus.pendValid = stageValid;
  assign bus.pendReg   = stageReg;
  assign bus.pendData  = stageData;
  assign bus.rdyA      = rdyA;
  assign bus.rdyB      = rdyB;
  assign bus.cntA      = cntA;
  assign bus.cntB      = cntB;
  assign bus.cntZero   = cntZero;

endmodule
